fifo_aximm_writer: RTL and testbench
====================================

// Module: fifo_aximm_writer
// PURPOSE
//  Downstream consumer of data_gen_fifo. Drains WIDTH-bit words from the shared write FIFO.
//  Writes them to memory as AXI4 INCR write bursts starting at base_addr.
//  total_words is supplied by the control layer (size*times) and is latched at ap_start.
//  One burst outstanding at a time; ap_* block-level handshake matches the neighbouring stages.
// PARAMETERS
//  WIDTH      32  data word / AXI WDATA width in bits (32, 64 or 128)
//  ADDR_W     32  AXI address width
//  BURST_LEN  16  max beats per burst (1..256); BURST_LEN*WIDTH/8 <= 4096
// PORTS
//  ap_clk          in   1         clock
//  ap_rst          in   1         synchronous reset, active-high
//  base_addr       in   ADDR_W    byte start address, aligned to BURST_LEN*WIDTH/8
//  total_words     in   32        words to transfer; 0 = complete with no AXI traffic
//  ap_start        in   1         start request (level, sampled in IDLE)
//  ap_done         out  1         1-cycle pulse when the last BRESP is accepted
//  ap_idle         out  1         high in IDLE
//  ap_ready        out  1         1-cycle pulse when ap_start is accepted
//  fifo_rd_en      out  1         FIFO pop; data valid the cycle after
//  fifo_rd_data    in   WIDTH     FIFO read data
//  fifo_empty      in   1         FIFO empty
//  m_axi_awaddr/awlen/awsize/awburst/awvalid/awready   AW channel (awburst=INCR, awsize=log2(WIDTH/8))
//  m_axi_wdata/wstrb/wlast/wvalid/wready               W channel (wstrb all ones)
//  m_axi_bresp/bvalid/bready                           B channel
// BEHAVIOUR
//  Reset: all outputs 0 except ap_idle=1. Counters cleared, state=IDLE. Reset mid-burst
//   abandons the transfer immediately; no further AXI valids are asserted.
//  States:
//   IDLE: ap_idle=1. On ap_start: ap_ready=1; latch base_addr into addr and total_words
//    into remain. Next state is DONE if total_words==0, else AW.
//   AW: beats=min(remain,BURST_LEN); awlen=beats-1; awvalid=1 until awready, then W.
//   W: beats driven from a 1-entry prefetch buffer.
//    fifo_rd_en = !fifo_empty && popped<beats && (!buf_v || (wvalid&&wready)).
//    buf_v is set the cycle after a pop. wvalid=buf_v.
//    wlast is high on beat index beats-1. After the wlast handshake -> B.
//    wvalid never drops once asserted until that beat's handshake.
//   B: bready=1. On bvalid: addr+=beats*WIDTH/8; remain-=beats. Next state is DONE if
//    remain==0, else AW.
//   DONE: ap_done=1 for one cycle -> IDLE.
//  Latency: first awvalid 1 cycle after ap_ready; first wvalid >=2 cycles after AW
//   handshake (FIFO read latency).
//  FIFO empty mid-burst: wvalid deasserts between beats, burst length is unchanged.
//   No pop ever occurs while fifo_empty=1.
//  Bursts never straddle 4 KB (alignment rule). The last burst is short when
//   total_words % BURST_LEN != 0.
//  ap_start while busy is ignored; inputs are only sampled in IDLE.
//  bresp is ignored unless BRESP_CHECK_EN is defined.
// CONFIGURATION
//  `define BRESP_CHECK_EN: adds outputs err (1) and err_cnt (16).
//   err_cnt is cleared at ap_start and counts B handshakes with bresp!=OKAY (saturates).
//   err is sticky until the next ap_start.
//   Without the macro: neither port exists and behaviour is otherwise identical.
// STRUCTURE
//  Package fifo_aximm_pkg: state enum (IDLE, AW, W, B, DONE); AXI_BURST_INCR=2'b01,
//   AXI_RESP_OKAY=2'b00; function clog2 for awsize.
//  No sub-modules. The prefetch buffer is inline, with the FSM and counters in one file.
// TESTING
//  1. total_words=40, BURST_LEN=16, base=0x1000, FIFO always full -> bursts awlen 15,15,7
//     at 0x1000,0x1040,0x1080; data order preserved; one ap_done.
//  2. total_words=0 -> ap_ready then ap_done 2 cycles later; no awvalid, no fifo_rd_en.
//  3. FIFO empty for 10 cycles mid-burst -> wvalid low throughout; no pop while empty;
//     wlast only on beat 15.
//  4. Random wready/awready/bvalid backpressure, total_words=100 -> wdata stable while
//     wvalid&&!wready; 100 beats; 7 bursts.
//  5. ap_rst pulsed during W state -> next cycle all valids 0, ap_idle=1; a fresh
//     ap_start completes normally.
//  6. BRESP_CHECK_EN, 3 bursts with bresp=SLVERR on the 2nd -> err_cnt=1, err=1;
//     cleared on next ap_start.

Source files
------------

// File: rtl/fifo_aximm_writer_pkg.sv
// fifo_aximm_pkg: shared FSM states, AXI encodings and awsize helper for fifo_aximm_writer
package fifo_aximm_pkg;
  typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/fifo_aximm_writer_if.sv
// fifo_aximm_writer_if: AXI4 write-only master bus (AW, W, B channels)
interface fifo_aximm_writer_if #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]  awaddr;
  logic [7:0]         awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic               awvalid;
  logic               awready;
  logic [WIDTH-1:0]   wdata;
  logic [WIDTH/8-1:0] wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/fifo_aximm_writer.sv
// fifo_aximm_writer: drains the write FIFO into AXI4 INCR bursts; `BRESP_CHECK_EN adds err/err_cnt outputs
module fifo_aximm_writer
  import fifo_aximm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ADDR_W = 32,
  parameter int BURST_LEN = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       total_words,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              fifo_rd_en,
  input  logic [WIDTH-1:0]  fifo_rd_data,
  input  logic              fifo_empty,
`ifdef BRESP_CHECK_EN
  output logic              err,
  output logic [15:0]       err_cnt,
`endif
  fifo_aximm_writer_if.master m_axi
);
  localparam logic [8:0] BLEN = 9'(BURST_LEN);
  localparam int BYTES = WIDTH / 8;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] remain_q, remain_d;
  logic [8:0] beats_q, beats_d, popped_q, popped_d, sent_q, sent_d, beats_w;
  logic buf_v_q, buf_v_d, pend_q, done_q, w_hs, pop;
  logic [WIDTH-1:0] buf_data_q, wdata_w;
  assign beats_w = (remain_q < 32'(BURST_LEN)) ? remain_q[8:0] : BLEN;
  assign w_hs = buf_v_q && m_axi.wready;
  assign pop = (state_q == W) && !fifo_empty && (popped_q < beats_q) && (!buf_v_q || w_hs);
  // Read data arrives the cycle after the pop; buf_data_q holds it while the beat stalls.
  assign wdata_w = pend_q ? fifo_rd_data : buf_data_q;
  assign buf_v_d = pop || (buf_v_q && !w_hs);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    remain_d = remain_q;
    beats_d = beats_q;
    popped_d = popped_q;
    sent_d = sent_q;
    case (state_q)
      IDLE: if (ap_start) begin
        addr_d = base_addr;
        remain_d = total_words;
        state_d = (total_words == 32'd0) ? DONE : AW;
      end
      AW: begin
        beats_d = beats_w;
        popped_d = '0;
        sent_d = '0;
        state_d = m_axi.awready ? W : AW;
      end
      W: begin
        popped_d = popped_q + 9'(pop);
        sent_d = sent_q + 9'(w_hs);
        state_d = (w_hs && m_axi.wlast) ? B : W;
      end
      B: if (m_axi.bvalid) begin
        addr_d = addr_q + ADDR_W'(beats_q) * ADDR_W'(BYTES);
        remain_d = remain_q - 32'(beats_q);
        state_d = (remain_q == 32'(beats_q)) ? DONE : AW;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      remain_q <= '0;
      beats_q <= '0;
      popped_q <= '0;
      sent_q <= '0;
      buf_v_q <= 1'b0;
      pend_q <= 1'b0;
      buf_data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      remain_q <= remain_d;
      beats_q <= beats_d;
      popped_q <= popped_d;
      sent_q <= sent_d;
      buf_v_q <= buf_v_d;
      pend_q <= pop;
      buf_data_q <= wdata_w;
      done_q <= (state_q == DONE);
    end
  end
  assign ap_idle = (state_q == IDLE);
  assign ap_ready = ap_idle && ap_start;
  assign ap_done = done_q;
  assign fifo_rd_en = pop;
  assign m_axi.awaddr = addr_q;
  assign m_axi.awlen = (state_q == AW) ? 8'(beats_w - 9'd1) : 8'd0;
  assign m_axi.awsize = 3'(clog2(BYTES));
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awvalid = (state_q == AW);
  assign m_axi.wdata = wdata_w;
  assign m_axi.wstrb = '1;
  assign m_axi.wlast = buf_v_q && (sent_q == beats_q - 9'd1);
  assign m_axi.wvalid = buf_v_q;
  assign m_axi.bready = (state_q == B);
`ifdef BRESP_CHECK_EN
  logic err_q, err_d, b_bad;
  logic [15:0] cnt_q, cnt_d;
  assign b_bad = (state_q == B) && m_axi.bvalid && (m_axi.bresp != AXI_RESP_OKAY);
  assign err_d = ap_ready ? 1'b0 : (err_q || b_bad);
  assign cnt_d = ap_ready ? 16'd0 : cnt_q + 16'(b_bad && (cnt_q != 16'hFFFF));
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign err = err_q;
  assign err_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fifo_aximm_writer.sv
// tb_fifo_aximm_writer: scoreboard bench with FIFO and AXI slave models for fifo_aximm_writer
module tb_fifo_aximm_writer;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic [31:0] base_addr = '0;
  logic [31:0] total_words = '0;
  logic ap_start = 1'b0;
  logic ap_done, ap_idle, ap_ready, fifo_rd_en, fifo_empty;
  logic [31:0] fifo_rd_data = '0;
  logic stall = 1'b0;
  logic rnd = 1'b0;
  int fifo_n = 0;
`ifdef BRESP_CHECK_EN
  logic err;
  logic [15:0] err_cnt;
`endif
  fifo_aximm_writer_if #(.WIDTH(32), .ADDR_W(32)) axi ();
  fifo_aximm_writer #(.WIDTH(32), .ADDR_W(32), .BURST_LEN(16)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .base_addr(base_addr), .total_words(total_words),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
`ifdef BRESP_CHECK_EN
    .err(err), .err_cnt(err_cnt),
`endif
    .m_axi(axi)
  );
  always #5 ap_clk = ~ap_clk;
  assign fifo_empty = (fifo_n == 0) || stall;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_w[$];
  logic [39:0] exp_aw[$];
  int n_chk = 0, n_err = 0;
  int cyc = 0, ready_cyc = 0, done_cyc = 0, done_cnt = 0;
  int aw_cnt = 0, awv_cnt = 0, w_cnt = 0, pop_cnt = 0, b_idx = 0, bad_burst = -1;
  int beat = 0, cur_len = 0;
  logic pop_f = 0, b_f = 0, wl_f = 0, b_pend = 0, prev_stall = 0, done_seen = 0;
  logic [31:0] prev_wdata = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  // AXI slave and FIFO model: apply last negedge's handshakes just after the clock edge
  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
    forever begin
      @(posedge ap_clk);
      cyc++;
      #1;
      if (pop_f && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
      fifo_n = fifo_q.size();
      if (b_f) begin axi.bvalid = 0; b_idx++; end
      if (wl_f) b_pend = 1;
      pop_f = 0; b_f = 0; wl_f = 0;
      if (b_pend && !axi.bvalid && (!rnd || $urandom_range(0, 2) == 0)) begin
        axi.bvalid = 1;
        axi.bresp = (b_idx == bad_burst) ? 2'b10 : 2'b00;
        b_pend = 0;
      end
      axi.awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  // Monitor: handshakes seen here complete at the following posedge
  initial begin
    forever begin
      @(negedge ap_clk);
      if (ap_rst) begin prev_stall = 0; continue; end
      if (fifo_rd_en) begin chk("no_pop_empty", fifo_empty, 0); pop_cnt++; pop_f = 1; end
      if (axi.awvalid) awv_cnt++;
      if (axi.awvalid && axi.awready) begin
        chk("aw_expected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) begin
          logic [39:0] e;
          e = exp_aw.pop_front();
          chk("awaddr", axi.awaddr, e[31:0]);
          chk("awlen", axi.awlen, e[39:32]);
        end
        cur_len = int'(axi.awlen); beat = 0; aw_cnt++;
      end
      if (prev_stall) chk("w_hold", {axi.wvalid, axi.wdata}, {1'b1, prev_wdata});
      if (axi.wvalid && axi.wready) begin
        chk("w_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) chk("wdata", axi.wdata, exp_w.pop_front());
        chk("wlast", axi.wlast, beat == cur_len);
        beat++; w_cnt++;
        if (axi.wlast) wl_f = 1;
      end
      prev_stall = axi.wvalid && !axi.wready;
      prev_wdata = axi.wdata;
      if (axi.bvalid && axi.bready) b_f = 1;
      if (ap_done) begin done_seen = 1; done_cyc = cyc; done_cnt++; end
    end
  end
  task automatic start_job(input logic [31:0] base, input int total);
    @(negedge ap_clk);
    #2;
    b_idx = 0; done_seen = 0;
    for (int off = 0; off < total; off += 16)
      exp_aw.push_back({8'(((total - off < 16) ? total - off : 16) - 1), base + 32'(off * 4)});
    for (int i = 0; i < total; i++) begin
      logic [31:0] d;
      d = $urandom;
      fifo_q.push_back(d);
      exp_w.push_back(d);
    end
    fifo_n = fifo_q.size();
    base_addr = base; total_words = 32'(total); ap_start = 1;
    #1;
    chk("ap_ready", ap_ready, 1);
    ready_cyc = cyc;
    @(posedge ap_clk);
    #1;
    ap_start = 0;
    base_addr = 32'hDEAD_BEEF; total_words = 32'd999;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 4000 && !done_seen; i++) @(posedge ap_clk);
    chk("done_seen", done_seen, 1);
    repeat (3) @(posedge ap_clk);
    chk("scoreboard_empty", {32'(exp_aw.size()), 32'(exp_w.size())}, 64'd0);
  endtask
  initial begin
    int a0, w0, p0, d0, v0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 0;
    @(negedge ap_clk);
    chk("rst_idle", {ap_idle, ap_done, ap_ready, fifo_rd_en}, 4'b1000);
    chk("rst_valids", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready}, 4'b0000);
    // 1: 40 words, no backpressure -> bursts of 16, 16, 8
    d0 = done_cnt; a0 = aw_cnt;
    start_job(32'h1000, 40);
    chk("t1_awsize", axi.awsize, 3'd2);
    chk("t1_awburst", axi.awburst, 2'b01);
    chk("t1_wstrb", axi.wstrb, 4'hF);
    wait_done();
    chk("t1_bursts", aw_cnt - a0, 3);
    chk("t1_done_once", done_cnt - d0, 1);
    // 2: zero-length job
    v0 = awv_cnt; p0 = pop_cnt;
    start_job(32'h7000, 0);
    wait_done();
    chk("t2_latency", done_cyc - ready_cyc, 2);
    chk("t2_no_aw", awv_cnt - v0, 0);
    chk("t2_no_pop", pop_cnt - p0, 0);
    // 3: FIFO empty for 10 cycles mid-burst
    p0 = pop_cnt;
    start_job(32'h8000, 16);
    for (int i = 0; i < 200 && pop_cnt < p0 + 6; i++) @(posedge ap_clk);
    chk("t3_reach_pop6", pop_cnt >= p0 + 6, 1);
    #1;
    stall = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      #2;
      if (i >= 1) chk("t3_stall_wvalid", axi.wvalid, 0);
    end
    @(posedge ap_clk);
    #1;
    stall = 0;
    wait_done();
    // 4: random backpressure, 100 words -> 7 bursts
    a0 = aw_cnt; w0 = w_cnt;
    rnd = 1;
    start_job(32'h2000, 100);
    wait_done();
    rnd = 0;
    chk("t4_bursts", aw_cnt - a0, 7);
    chk("t4_beats", w_cnt - w0, 100);
    // 5: reset during W, then a fresh job
    w0 = w_cnt;
    start_job(32'h3000, 40);
    for (int i = 0; i < 200 && w_cnt < w0 + 3; i++) @(posedge ap_clk);
    chk("t5_in_w", w_cnt >= w0 + 3, 1);
    #1;
    ap_rst = 1;
    @(posedge ap_clk);
    #1;
    ap_rst = 0;
    @(negedge ap_clk);
    #2;
    chk("t5_valids", {axi.awvalid, axi.wvalid, axi.bready, fifo_rd_en}, 4'b0000);
    chk("t5_idle", {ap_idle, ap_done}, 2'b10);
    fifo_q.delete(); exp_w.delete(); exp_aw.delete();
    fifo_n = 0; b_pend = 0; axi.bvalid = 0; pop_f = 0; b_f = 0; wl_f = 0;
    start_job(32'h4000, 20);
    wait_done();
`ifdef BRESP_CHECK_EN
    // 6: SLVERR on the second of three bursts
    bad_burst = 1;
    start_job(32'h5000, 48);
    wait_done();
    bad_burst = -1;
    chk("t6_err_cnt", err_cnt, 16'd1);
    chk("t6_err", err, 1);
    start_job(32'h6000, 0);
    chk("t6_err_clear", {err, err_cnt}, 17'd0);
    wait_done();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
